axi_ax_arbiter: RTL and testbench



---
 rtl/axi_pkg.sv | 23 ++
 rtl/axi_ax_arbiter.sv | 92 +++++++++
 tb/tb_axi_ax_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// ============================================================================
// axi_pkg : shared AXI definitions (widths, master count, arbiter state enum)
// Revision: 1.0
// ============================================================================
`default_nettype none

package axi_pkg;

  localparam int unsigned AXI_ADDR_W      = 32;
  localparam int unsigned AXI_DATA_W      = 64;
  localparam int unsigned AXI_ID_W        = 4;
  localparam int unsigned AXI_LEN_W       = 8;
  localparam int unsigned AXI_NUM_MASTERS = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/axi_ax_arbiter.sv
// ============================================================================
// axi_ax_arbiter : two-master round-robin arbiter for one AXI address channel
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_ax_arbiter
  import axi_pkg::*;
#(
  parameter bit W_LOCK = 1'b0
) (
  input  logic ACLK,
  input  logic ARESET,
  input  logic AxVALID_M0,
  input  logic AxVALID_M1,
  input  logic AxREADY_S,
  input  logic WVALID,
  input  logic WREADY,
  input  logic WLAST,
  output logic gnt,
  output logic AxREADY_M0,
  output logic AxREADY_M1,
  output logic w_open,
  output logic busy
);

  arb_state_e                 state;
  logic                       rr_ptr;
  logic                       wlast_seen;
  logic [AXI_NUM_MASTERS-1:0] ax_valid;
  logic                       ax_hs;
  logic                       wlast_hs;

  assign ax_valid = {AxVALID_M1, AxVALID_M0};
  assign ax_hs    = ax_valid[gnt] & AxREADY_S;
  // W beats only matter for the AW copy; the AR copy never sees a WLAST.
  assign wlast_hs = W_LOCK & WVALID & WREADY & WLAST;

  // Ready depends only on state/gnt/slave ready, never on master valid.
  assign AxREADY_M0 = (state == ADDR) & ~gnt & AxREADY_S;
  assign AxREADY_M1 = (state == ADDR) &  gnt & AxREADY_S;
  assign w_open     = W_LOCK & ((state == ADDR) | (state == DATA));
  assign busy       = (state != IDLE);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      rr_ptr     <= 1'b0;
      wlast_seen <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wlast_seen <= 1'b0;
          if (&ax_valid) begin
            gnt   <= rr_ptr;
            state <= ADDR;
          end else if (|ax_valid) begin
            gnt   <= AxVALID_M1;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (ax_hs) begin
            rr_ptr <= ~gnt;
            // W data may have fully led the address; then no DATA phase.
            if (!W_LOCK || wlast_seen || wlast_hs) begin
              state      <= IDLE;
              wlast_seen <= 1'b0;
            end else begin
              state <= DATA;
            end
          end else if (wlast_hs) begin
            wlast_seen <= 1'b1;
          end
        end
        DATA: begin
          if (wlast_hs) begin
            state      <= IDLE;
            wlast_seen <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_ax_arbiter.sv
// ============================================================================
// tb_axi_ax_arbiter : AR (W_LOCK=0) and AW (W_LOCK=1) arbiters vs. a transaction model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_ax_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, v0, v1, rs, wv, wr, wl;
  logic [1:0] gnt_o, rdy0_o, rdy1_o, wopen_o, busy_o;

  axi_ax_arbiter #(.W_LOCK(1'b0)) u_ar (
    .ACLK(clk), .ARESET(rst), .AxVALID_M0(v0), .AxVALID_M1(v1), .AxREADY_S(rs),
    .WVALID(wv), .WREADY(wr), .WLAST(wl), .gnt(gnt_o[0]), .AxREADY_M0(rdy0_o[0]),
    .AxREADY_M1(rdy1_o[0]), .w_open(wopen_o[0]), .busy(busy_o[0]));

  axi_ax_arbiter #(.W_LOCK(1'b1)) u_aw (
    .ACLK(clk), .ARESET(rst), .AxVALID_M0(v0), .AxVALID_M1(v1), .AxREADY_S(rs),
    .WVALID(wv), .WREADY(wr), .WLAST(wl), .gnt(gnt_o[1]), .AxREADY_M0(rdy0_o[1]),
    .AxREADY_M1(rdy1_o[1]), .w_open(wopen_o[1]), .busy(busy_o[1]));

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an open transaction owned by one master, closed once
  // its address is accepted and (for AW) its last W beat has been accepted.
  bit m_act[2], m_own[2], m_prio[2], m_adone[2], m_wdone[2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 0; m_own[i] = 0; m_prio[i] = 0; m_adone[i] = 0; m_wdone[i] = 0;
      end else if (!m_act[i]) begin
        if (v0 || v1) begin
          m_own[i]   = (v0 && v1) ? m_prio[i] : v1;
          m_act[i]   = 1;
          m_adone[i] = 0;
          m_wdone[i] = 0;
        end
      end else begin
        if (!m_adone[i] && (m_own[i] ? v1 : v0) && rs) begin
          m_adone[i] = 1;
          m_prio[i]  = !m_own[i];
        end
        if (i == 1 && wv && wr && wl) m_wdone[i] = 1;
        if (m_adone[i] && (i == 0 || m_wdone[i])) m_act[i] = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("gnt[%0d]", i),    gnt_o[i],   m_own[i]);
        chk($sformatf("busy[%0d]", i),   busy_o[i],  m_act[i]);
        chk($sformatf("w_open[%0d]", i), wopen_o[i], (i == 1) && m_act[i]);
        chk($sformatf("rdy0[%0d]", i),   rdy0_o[i],  m_act[i] && !m_adone[i] && !m_own[i] && rs);
        chk($sformatf("rdy1[%0d]", i),   rdy1_o[i],  m_act[i] && !m_adone[i] &&  m_own[i] && rs);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic seq[$];

  initial begin
    rst = 1; v0 = 0; v1 = 0; rs = 0; wv = 0; wr = 0; wl = 0;
    tick();
    chk_en = 1;
    tick();
    chk("reset_gnt_ar", gnt_o[0], 1'b0);
    chk("reset_busy_aw", busy_o[1], 1'b0);
    chk("reset_wopen_aw", wopen_o[1], 1'b0);
    rst = 0;

    // single master M1
    v1 = 1;
    tick();
    chk("single_gnt_ar", gnt_o[0], 1'b1);
    chk("single_rdy1_low", rdy1_o[0], 1'b0);
    rs = 1; #1;
    chk("single_rdy1_follows", rdy1_o[0], 1'b1);
    chk("single_rdy0_low", rdy0_o[0], 1'b0);
    tick();
    chk("single_ar_idle", busy_o[0], 1'b0);
    chk("single_aw_data", busy_o[1], 1'b1);
    v1 = 0; rs = 0; wv = 1; wr = 1; wl = 1;
    tick();
    chk("single_aw_idle", busy_o[1], 1'b0);

    // contention: both valid, slave always ready, WLAST every cycle
    v0 = 1; v1 = 1; rs = 1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("cont_busy_ar", busy_o[0], (k % 2) == 1);
      if (busy_o[0]) seq.push_back(gnt_o[0]);
    end
    chk("cont_len", seq.size() == 4, 1'b1);
    for (int k = 0; k < 4 && k < seq.size(); k++)
      chk($sformatf("cont_seq%0d", k), seq[k], (k % 2) == 1);
    v0 = 0; v1 = 0; rs = 0; wv = 0; wr = 0; wl = 0;
    tick();

    // backpressure on M0 while M1 waits
    v0 = 1;
    tick();
    v1 = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_gnt_ar", gnt_o[0], 1'b0);
      chk("bp_rdy1", rdy1_o[0], 1'b0);
    end
    rs = 1;
    tick();
    v0 = 0; rs = 0;
    tick();
    chk("bp_m1_granted_ar", gnt_o[0], 1'b1);
    chk("wl_aw_held", gnt_o[1], 1'b0);

    // W lock: four beats, WLAST on the fourth
    wv = 1; wr = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("wl_wopen", wopen_o[1], 1'b1);
      chk("wl_gnt_held", gnt_o[1], 1'b0);
    end
    wl = 1;
    tick();
    chk("wl_idle_after_last", busy_o[1], 1'b0);
    wv = 0; wr = 0; wl = 0;
    tick();
    chk("wl_m1_granted", gnt_o[1], 1'b1);
    rs = 1;
    tick();
    v1 = 0; rs = 0; wv = 1; wr = 1; wl = 1;
    tick();
    wv = 0; wr = 0; wl = 0;

    // W before AW: WLAST leads the address handshake
    v0 = 1;
    tick();
    wv = 1; wr = 1; wl = 1;
    tick();
    chk("wfirst_still_addr", busy_o[1], 1'b1);
    wv = 0; wr = 0; wl = 0; rs = 1;
    tick();
    chk("wfirst_idle", busy_o[1], 1'b0);
    v0 = 0; rs = 0;
    tick();
    // WLAST and AW handshake in the same cycle
    v0 = 1;
    tick();
    rs = 1; wv = 1; wr = 1; wl = 1;
    tick();
    chk("wsame_idle", busy_o[1], 1'b0);
    v0 = 0; rs = 0; wv = 0; wr = 0; wl = 0;
    tick();

    // reset while the AW copy sits in DATA
    v1 = 1;
    tick();
    rs = 1;
    tick();
    v1 = 0; rs = 0;
    chk("mid_pre_data", busy_o[1], 1'b1);
    rst = 1;
    tick();
    chk("mid_gnt", gnt_o[1], 1'b0);
    chk("mid_busy", busy_o[1], 1'b0);
    chk("mid_wopen", wopen_o[1], 1'b0);
    rst = 0;
    v0 = 1; v1 = 1;
    tick();
    chk("mid_ptr_zero", gnt_o[1], 1'b0);
    v0 = 0; v1 = 0; rs = 1;
    tick();
    rs = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
